capture_seq: RTL and testbench
==============================

CAPTURE_SEQ -- requirements
Module: capture_seq

Interface
REQ-001 SHALL have parameter size, default 32, sample width in bits.
REQ-002 SHALL have parameter levels, default 8, number of trigger stages.
REQ-003 SHALL have parameter saddr_w, default 24, post-trigger counter width.
REQ-004 SHALL have port clk  in  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port arm, abort  in  1 each  single-cycle control pulses.
REQ-007 SHALL have port smp_data  in  size, and port smp_valid  in  1, the sampled input stream.
REQ-008 SHALL have port trig_mask, trig_type, trig_level  in  levels*size each; stage k occupies bits [k*size +: size].
REQ-009 SHALL have port num_levels  in  4  stages in use; 0 is treated as 1; values above levels are clamped to levels.
REQ-010 SHALL have port post_count  in  saddr_w  samples kept after the trigger sample.
REQ-011 SHALL have port cap_data  out  size, port cap_valid  out  1, port cap_last  out  1, and port cap_ready  in  1, the FIFO-facing stream.
REQ-012 SHALL have port armed, triggered, done, overrun  out  1 each, status levels.
REQ-013 SHALL have port stage  out  4  index of the trigger stage being evaluated.

Function
REQ-014 SHALL implement FSM IDLE, ARMED, POST, DONE.
REQ-015 arm in IDLE or DONE SHALL enter ARMED, clear stage, triggered, done and overrun, and invalidate the previous-sample register; arm in ARMED or POST SHALL be ignored.
REQ-016 abort SHALL force IDLE from any state with no cap_last; abort wins over a simultaneous arm.
REQ-017 Stage match, per bit i with mask=1: type=0 requires data[i]==level[i]; type=1 (edge) requires prev[i]!=data[i] and data[i]==level[i]; mask=0 bits are ignored; an all-zero mask matches any valid sample.
REQ-018 Edge bits SHALL NOT match on the first valid sample after arm, because no previous sample exists.
REQ-019 In ARMED, a matching valid sample SHALL increment stage; a match on stage num_levels-1 SHALL set triggered, enter POST, and clear the post counter.
REQ-020 The trigger sample SHALL be output; POST SHALL then pass exactly post_count further valid samples, and the last output sample SHALL carry cap_last=1 before the FSM enters DONE.
REQ-021 With post_count=0, the trigger sample SHALL carry cap_last and the FSM SHALL go directly to DONE.
REQ-022 In ARMED and POST, every valid sample (pre-trigger included) SHALL be forwarded; in IDLE and DONE, none SHALL be forwarded.
REQ-023 Output SHALL be registered with 1-cycle latency: cap_data, cap_valid and cap_last reflect the sample of the previous cycle.
REQ-024 No stall: a forwarded sample while cap_ready=0 SHALL be dropped and SHALL set overrun, which stays sticky until arm or reset; counting and triggering SHALL continue.
REQ-025 armed SHALL be 1 in ARMED and POST; done SHALL be 1 in DONE and held until arm, abort or reset.
REQ-026 The post counter SHALL be saddr_w bits and SHALL not wrap; post_count = 2^saddr_w-1 SHALL be supported.

Reset
REQ-027 reset SHALL force IDLE, with stage=0, and cap_valid, cap_last, armed, triggered, done and overrun all 0; cap_data SHALL be 0.
REQ-028 reset mid-capture SHALL behave as abort, with reset taking priority over all inputs.

Structure
REQ-029 A shared capture_pkg SHALL hold the FSM state encoding, the trigger type encoding (LEVEL=0, EDGE=1) and the default LEVELS/SADDR_W constants.
REQ-030 A single sub-module, trig_match (one stage comparator: mask, type, level, data, prev, prev_valid -> match), SHALL be instantiated once and muxed by stage.

Verification
REQ-031 The bench SHALL cover: num_levels=1, mask=0x1, type=0, level=0x1, post_count=3; stream 0,0,1,2,3,4 -> triggered on the sample 1, 2 pre-trigger samples forwarded, cap_last on sample 4, then DONE.
REQ-032 The bench SHALL cover: num_levels=2, stage0 level 0xA/mask 0xF, stage1 edge bit0 rising; stream 0xA,0x0,0x1 -> stage 0->1 on 0xA, trigger on 0x1.
REQ-033 The bench SHALL cover: post_count=0 -> the trigger sample has cap_last=1 and done=1 on the next cycle.
REQ-034 The bench SHALL cover: abort and arm in the same cycle during POST -> IDLE, no cap_last, armed=0.
REQ-035 The bench SHALL cover: cap_ready=0 for one forwarded sample -> overrun=1 stays set until the next arm, and the post count is unaffected.
REQ-036 The bench SHALL cover: edge-only trigger with the first sample after arm equal to level -> no match until a real transition occurs.

Source files
------------

// File: rtl/capture_pkg.sv
`default_nettype none
// ============================================================
// capture_pkg : shared encodings for the capture sequencer
// Rev 1.0
// ============================================================
package capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic TRIG_LEVEL = 1'b0;
    localparam logic TRIG_EDGE  = 1'b1;

    localparam int LEVELS  = 8;
    localparam int SADDR_W = 24;

endpackage
`default_nettype wire

// File: rtl/capture_seq_if.sv
`default_nettype none
// ============================================================
// capture_seq_if : FIFO-facing capture output stream
// Rev 1.0
// ============================================================
interface capture_seq_if #(
    parameter int size = 32
) ();
    logic [size-1:0] cap_data;
    logic            cap_valid;
    logic            cap_last;
    logic            cap_ready;

    modport master (output cap_data, output cap_valid, output cap_last, input cap_ready);
    modport slave  (input cap_data, input cap_valid, input cap_last, output cap_ready);
endinterface
`default_nettype wire

// File: rtl/capture_seq_trig_match.sv
`default_nettype none
// ============================================================
// trig_match : single trigger-stage comparator
// Rev 1.0
// ============================================================
module trig_match
    import capture_pkg::*;
#(
    parameter int size = 32
) (
    input  wire logic [size-1:0] mask_i,
    input  wire logic [size-1:0] type_i,
    input  wire logic [size-1:0] level_i,
    input  wire logic [size-1:0] data_i,
    input  wire logic [size-1:0] prev_i,
    input  wire logic            prev_valid_i,
    output logic                 match_o
);

    always_comb begin
        match_o = 1'b1;
        for (int i = 0; i < size; i++) begin
            if (mask_i[i]) begin
                if (data_i[i] != level_i[i]) begin
                    match_o = 1'b0;
                end else if (type_i[i] == TRIG_EDGE &&
                             !(prev_valid_i && (prev_i[i] != data_i[i]))) begin
                    match_o = 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/capture_seq.sv
`default_nettype none
// ============================================================
// capture_seq : multi-stage trigger with post-trigger capture
// Rev 1.0
// ============================================================
module capture_seq
    import capture_pkg::*;
#(
    parameter int size    = 32,
    parameter int levels  = LEVELS,
    parameter int saddr_w = SADDR_W
) (
    input  wire logic                   clk,
    input  wire logic                   reset,
    input  wire logic                   arm,
    input  wire logic                   abort,
    input  wire logic [size-1:0]        smp_data,
    input  wire logic                   smp_valid,
    input  wire logic [levels*size-1:0] trig_mask,
    input  wire logic [levels*size-1:0] trig_type,
    input  wire logic [levels*size-1:0] trig_level,
    input  wire logic [3:0]             num_levels,
    input  wire logic [saddr_w-1:0]     post_count,
    capture_seq_if.master               cap,
    output logic                        armed,
    output logic                        triggered,
    output logic                        done,
    output logic                        overrun,
    output logic [3:0]                  stage
);

    localparam logic [4:0] c_levels = 5'(levels);

    state_t              state_q;
    logic [3:0]          stage_q;
    logic [saddr_w-1:0]  post_cnt_q;
    logic [saddr_w-1:0]  post_cnt_d;
    logic [size-1:0]     prev_q;
    logic                prev_valid_q;
    logic [size-1:0]     cap_data_q;
    logic                cap_valid_q;
    logic                cap_last_q;
    logic                armed_q;
    logic                triggered_q;
    logic                done_q;
    logic                overrun_q;

    logic [3:0]          w_last_stage;
    logic [size-1:0]     w_mask;
    logic [size-1:0]     w_type;
    logic [size-1:0]     w_level;
    logic                w_match;
    logic                w_fwd;
    logic                w_hit;
    logic                w_post_end;
    logic                w_last;

    always_comb begin
        w_last_stage = 4'd0;
        if (num_levels == 4'd0) begin
            w_last_stage = 4'd0;
        end else if (5'(num_levels) > c_levels) begin
            w_last_stage = 4'(c_levels - 5'd1);
        end else begin
            w_last_stage = num_levels - 4'd1;
        end
    end

    always_comb begin
        w_mask  = '0;
        w_type  = '0;
        w_level = '0;
        for (int k = 0; k < levels; k++) begin
            if (stage_q == 4'(k)) begin
                w_mask  = trig_mask[k*size +: size];
                w_type  = trig_type[k*size +: size];
                w_level = trig_level[k*size +: size];
            end
        end
    end

    trig_match #(
        .size (size)
    ) u_trig_match (
        .mask_i       (w_mask),
        .type_i       (w_type),
        .level_i      (w_level),
        .data_i       (smp_data),
        .prev_i       (prev_q),
        .prev_valid_i (prev_valid_q),
        .match_o      (w_match)
    );

    // Ranges use >= so a num_levels/post_count change mid-capture cannot make a counter wrap.
    assign post_cnt_d = post_cnt_q + saddr_w'(1);
    assign w_fwd      = smp_valid && (state_q == ST_ARMED || state_q == ST_POST);
    assign w_hit      = smp_valid && (state_q == ST_ARMED) && w_match && (stage_q >= w_last_stage);
    assign w_post_end = smp_valid && (state_q == ST_POST) && (post_cnt_d >= post_count);
    assign w_last     = (w_hit && (post_count == '0)) || w_post_end;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            stage_q      <= 4'd0;
            post_cnt_q   <= '0;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            cap_data_q   <= '0;
            cap_valid_q  <= 1'b0;
            cap_last_q   <= 1'b0;
            armed_q      <= 1'b0;
            triggered_q  <= 1'b0;
            done_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else if (abort) begin
            state_q     <= ST_IDLE;
            cap_valid_q <= 1'b0;
            cap_last_q  <= 1'b0;
            armed_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            cap_valid_q <= w_fwd && cap.cap_ready;
            cap_last_q  <= w_fwd && cap.cap_ready && w_last;
            if (w_fwd && cap.cap_ready) begin
                cap_data_q <= smp_data;
            end
            if (w_fwd && !cap.cap_ready) begin
                overrun_q <= 1'b1;
            end
            if (w_fwd) begin
                prev_q       <= smp_data;
                prev_valid_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (arm) begin
                        state_q      <= ST_ARMED;
                        stage_q      <= 4'd0;
                        prev_valid_q <= 1'b0;
                        armed_q      <= 1'b1;
                        triggered_q  <= 1'b0;
                        done_q       <= 1'b0;
                        overrun_q    <= 1'b0;
                    end
                end
                ST_ARMED: begin
                    if (w_hit) begin
                        triggered_q <= 1'b1;
                        post_cnt_q  <= '0;
                        if (post_count == '0) begin
                            state_q <= ST_DONE;
                            armed_q <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_POST;
                        end
                    end else if (smp_valid && w_match) begin
                        stage_q <= stage_q + 4'd1;
                    end
                end
                ST_POST: begin
                    if (smp_valid) begin
                        post_cnt_q <= post_cnt_d;
                        if (w_post_end) begin
                            state_q <= ST_DONE;
                            armed_q <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cap.cap_data  = cap_data_q;
    assign cap.cap_valid = cap_valid_q;
    assign cap.cap_last  = cap_last_q;
    assign armed         = armed_q;
    assign triggered     = triggered_q;
    assign done          = done_q;
    assign overrun       = overrun_q;
    assign stage         = stage_q;

endmodule
`default_nettype wire

// File: tb/tb_capture_seq.sv
`default_nettype none
// ============================================================
// tb_capture_seq : directed table-driven bench for capture_seq
// Rev 1.0
// ============================================================
module tb_capture_seq;
    import capture_pkg::*;

    localparam int SZ = 32;
    localparam int LV = 8;
    localparam int SW = 24;

    logic               clk = 1'b0;
    logic               reset, arm, abort, smp_valid;
    logic [SZ-1:0]      smp_data;
    logic [LV*SZ-1:0]   trig_mask, trig_type, trig_level;
    logic [3:0]         num_levels;
    logic [SW-1:0]      post_count;
    logic               armed, triggered, done, overrun;
    logic [3:0]         stage;

    capture_seq_if #(.size(SZ)) cap_if ();

    capture_seq #(.size(SZ), .levels(LV), .saddr_w(SW)) dut (
        .clk        (clk),
        .reset      (reset),
        .arm        (arm),
        .abort      (abort),
        .smp_data   (smp_data),
        .smp_valid  (smp_valid),
        .trig_mask  (trig_mask),
        .trig_type  (trig_type),
        .trig_level (trig_level),
        .num_levels (num_levels),
        .post_count (post_count),
        .cap        (cap_if.master),
        .armed      (armed),
        .triggered  (triggered),
        .done       (done),
        .overrun    (overrun),
        .stage      (stage)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]    nl;
        logic [SZ-1:0] m0, t0, l0, m1, t1, l1;
        logic [SW-1:0] post;
    } cfg_t;

    typedef struct {
        int            cfg;
        bit            arm, abort, vld, rdy;
        logic [SZ-1:0] d;
        bit            ev, el, ea, et, edn, eo;
        logic [SZ-1:0] ed;
        logic [3:0]    es;
    } vec_t;

    cfg_t cfgs[5];
    vec_t vecs[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    function automatic vec_t mk(int c, bit a, bit ab, bit v, logic [SZ-1:0] d, bit r,
                                bit ev, logic [SZ-1:0] ed, bit el,
                                bit ea, bit et, bit edn, bit eo, logic [3:0] es);
        vec_t x;
        x.cfg = c; x.arm = a; x.abort = ab; x.vld = v; x.d = d; x.rdy = r;
        x.ev = ev; x.ed = ed; x.el = el; x.ea = ea; x.et = et; x.edn = edn; x.eo = eo; x.es = es;
        return x;
    endfunction

    function automatic logic [9:0] status();
        return {cap_if.cap_valid, cap_if.cap_last, armed, triggered, done, overrun, stage};
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic set_cfg(int i);
        trig_mask  = '0;
        trig_type  = '0;
        trig_level = '0;
        trig_mask[SZ-1:0]     = cfgs[i].m0;
        trig_type[SZ-1:0]     = cfgs[i].t0;
        trig_level[SZ-1:0]    = cfgs[i].l0;
        trig_mask[2*SZ-1:SZ]  = cfgs[i].m1;
        trig_type[2*SZ-1:SZ]  = cfgs[i].t1;
        trig_level[2*SZ-1:SZ] = cfgs[i].l1;
        num_levels = cfgs[i].nl;
        post_count = cfgs[i].post;
    endtask

    task automatic drive(bit rs, bit a, bit ab, bit v, logic [SZ-1:0] d, bit r);
        reset = rs; arm = a; abort = ab; smp_valid = v; smp_data = d; cap_if.cap_ready = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // nl, m0, t0, l0, m1, t1, l1, post
        cfgs[0] = '{4'd1, 32'h1,  32'h0, 32'h1,  32'h0, 32'h0, 32'h0, 24'd3};
        cfgs[1] = '{4'd2, 32'hF,  32'h0, 32'hA,  32'h1, 32'h1, 32'h1, 24'd1};
        cfgs[2] = '{4'd0, 32'hFF, 32'h0, 32'h5A, 32'h0, 32'h0, 32'h0, 24'd0};
        cfgs[3] = '{4'd1, 32'h1,  32'h1, 32'h1,  32'h0, 32'h0, 32'h0, 24'd0};
        cfgs[4] = '{4'd1, 32'h1,  32'h0, 32'h1,  32'h0, 32'h0, 32'h0, 24'd2};

        // cfg arm abt vld data rdy | v data last | armed trig done ovr stage
        // level trigger, two pre-trigger samples, three post samples
        vecs.push_back(mk(0, 1, 0, 0, 32'h0, 1, 0, 32'h0, 0, 1, 0, 0, 0, 4'd0));
        vecs.push_back(mk(0, 0, 0, 1, 32'h0, 1, 1, 32'h0, 0, 1, 0, 0, 0, 4'd0));
        vecs.push_back(mk(0, 0, 0, 1, 32'h0, 1, 1, 32'h0, 0, 1, 0, 0, 0, 4'd0));
        vecs.push_back(mk(0, 0, 0, 1, 32'h1, 1, 1, 32'h1, 0, 1, 1, 0, 0, 4'd0));
        vecs.push_back(mk(0, 0, 0, 1, 32'h2, 1, 1, 32'h2, 0, 1, 1, 0, 0, 4'd0));
        vecs.push_back(mk(0, 0, 0, 1, 32'h3, 1, 1, 32'h3, 0, 1, 1, 0, 0, 4'd0));
        vecs.push_back(mk(0, 0, 0, 1, 32'h4, 1, 1, 32'h4, 1, 0, 1, 1, 0, 4'd0));
        vecs.push_back(mk(0, 0, 0, 1, 32'h5, 1, 0, 32'h0, 0, 0, 1, 1, 0, 4'd0));
        // two stages: level 0xA then rising edge on bit0; arm while armed is ignored
        vecs.push_back(mk(1, 1, 0, 0, 32'h0, 1, 0, 32'h0, 0, 1, 0, 0, 0, 4'd0));
        vecs.push_back(mk(1, 0, 0, 1, 32'hA, 1, 1, 32'hA, 0, 1, 0, 0, 0, 4'd1));
        vecs.push_back(mk(1, 1, 0, 0, 32'h0, 1, 0, 32'h0, 0, 1, 0, 0, 0, 4'd1));
        vecs.push_back(mk(1, 0, 0, 1, 32'h0, 1, 1, 32'h0, 0, 1, 0, 0, 0, 4'd1));
        vecs.push_back(mk(1, 0, 0, 1, 32'h1, 1, 1, 32'h1, 0, 1, 1, 0, 0, 4'd1));
        vecs.push_back(mk(1, 0, 0, 1, 32'h7, 1, 1, 32'h7, 1, 0, 1, 1, 0, 4'd1));
        // num_levels=0 acts as 1, post_count=0
        vecs.push_back(mk(2, 1, 0, 0, 32'h0,  1, 0, 32'h0,  0, 1, 0, 0, 0, 4'd0));
        vecs.push_back(mk(2, 0, 0, 1, 32'h11, 1, 1, 32'h11, 0, 1, 0, 0, 0, 4'd0));
        vecs.push_back(mk(2, 0, 0, 1, 32'h5A, 1, 1, 32'h5A, 1, 0, 1, 1, 0, 4'd0));
        // edge-only: first sample equal to level must not match
        vecs.push_back(mk(3, 1, 0, 0, 32'h0, 1, 0, 32'h0, 0, 1, 0, 0, 0, 4'd0));
        vecs.push_back(mk(3, 0, 0, 1, 32'h1, 1, 1, 32'h1, 0, 1, 0, 0, 0, 4'd0));
        vecs.push_back(mk(3, 0, 0, 1, 32'h1, 1, 1, 32'h1, 0, 1, 0, 0, 0, 4'd0));
        vecs.push_back(mk(3, 0, 0, 1, 32'h0, 1, 1, 32'h0, 0, 1, 0, 0, 0, 4'd0));
        vecs.push_back(mk(3, 0, 0, 1, 32'h1, 1, 1, 32'h1, 1, 0, 1, 1, 0, 4'd0));
        // dropped post sample: overrun sticky, post count unaffected
        vecs.push_back(mk(4, 1, 0, 0, 32'h0, 1, 0, 32'h0, 0, 1, 0, 0, 0, 4'd0));
        vecs.push_back(mk(4, 0, 0, 1, 32'h1, 1, 1, 32'h1, 0, 1, 1, 0, 0, 4'd0));
        vecs.push_back(mk(4, 0, 0, 1, 32'h2, 0, 0, 32'h0, 0, 1, 1, 0, 1, 4'd0));
        vecs.push_back(mk(4, 0, 0, 1, 32'h3, 1, 1, 32'h3, 1, 0, 1, 1, 1, 4'd0));
        vecs.push_back(mk(4, 0, 0, 1, 32'h9, 1, 0, 32'h0, 0, 0, 1, 1, 1, 4'd0));
        vecs.push_back(mk(4, 1, 0, 0, 32'h0, 1, 0, 32'h0, 0, 1, 0, 0, 0, 4'd0));

        set_cfg(0);
        drive(1, 0, 0, 0, 32'h0, 1);
        drive(1, 0, 0, 0, 32'h0, 1);
        chk("reset status", 64'(status()), 64'h0);
        chk("reset cap_data", 64'(cap_if.cap_data), 64'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            set_cfg(vecs[i].cfg);
            drive(0, vecs[i].arm, vecs[i].abort, vecs[i].vld, vecs[i].d, vecs[i].rdy);
            chk($sformatf("vec%0d status", i), 64'(status()),
                64'({vecs[i].ev, vecs[i].el, vecs[i].ea, vecs[i].et, vecs[i].edn, vecs[i].eo, vecs[i].es}));
            if (vecs[i].ev)
                chk($sformatf("vec%0d data", i), 64'(cap_if.cap_data), 64'(vecs[i].ed));
        end

        // abort together with arm during POST
        drive(0, 0, 0, 1, 32'h1, 1);
        chk("post entered", 64'({armed, triggered, cap_if.cap_valid}), 64'b111);
        drive(0, 1, 1, 1, 32'h2, 1);
        chk("abort+arm", 64'({cap_if.cap_valid, cap_if.cap_last, armed, done}), 64'h0);
        drive(0, 0, 0, 1, 32'h1, 1);
        chk("idle no forward", 64'({cap_if.cap_valid, armed, done}), 64'h0);
        drive(0, 1, 0, 0, 32'h0, 1);
        chk("rearm from idle", 64'({armed, triggered, stage}), 64'({1'b1, 1'b0, 4'd0}));

        // reset mid-capture beats a simultaneous arm and valid sample
        drive(0, 0, 0, 1, 32'h1, 1);
        chk("post again", 64'({armed, triggered}), 64'b11);
        drive(1, 1, 0, 1, 32'h5, 1);
        chk("reset mid status", 64'(status()), 64'h0);
        chk("reset mid data", 64'(cap_if.cap_data), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
